// File: rtl/regfile_arb_pkg.sv
// Shared types and sizes for the two-requester register-file port arbiter.
package regfile_arb_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_NUM_W = 2;
  localparam int NUM_REQ   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // One-hot grant selection from the request pair and last winner
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file port (1 write, 2 reads) between two requesters with
// a three-phase IDLE -> ISSUE -> RESP transaction per grant.
module regfile_port_arbiter #(
  parameter int DATA_W  = regfile_arb_pkg::DATA_W,
  parameter int NUM_REQ = regfile_arb_pkg::NUM_REQ
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ-1:0]                            req_write,
  input  logic [NUM_REQ*regfile_arb_pkg::REG_NUM_W-1:0] req_wr_num,
  input  logic [NUM_REQ*regfile_arb_pkg::REG_NUM_W-1:0] req_rd1_num,
  input  logic [NUM_REQ*regfile_arb_pkg::REG_NUM_W-1:0] req_rd2_num,
  input  logic [NUM_REQ*DATA_W-1:0]                     req_wdata,
  output logic [NUM_REQ-1:0]                            rsp_valid,
  input  logic [NUM_REQ-1:0]                            rsp_ready,
  output logic [DATA_W-1:0]                             rsp_data1,
  output logic [DATA_W-1:0]                             rsp_data2,
  output logic                                          rf_write_enable,
  output logic [regfile_arb_pkg::REG_NUM_W-1:0]         rf_write_reg_num,
  output logic [regfile_arb_pkg::REG_NUM_W-1:0]         rf_read_reg_1_num,
  output logic [regfile_arb_pkg::REG_NUM_W-1:0]         rf_read_reg_2_num,
  output logic [DATA_W-1:0]                             rf_write_data,
  input  logic [DATA_W-1:0]                             rf_read_data_1,
  input  logic [DATA_W-1:0]                             rf_read_data_2,
  output logic                                          busy
);
  import regfile_arb_pkg::*;

  state_e                 r_state;
  logic                   r_last_gnt;
  logic [NUM_REQ-1:0]     r_gnt;
  logic                   r_we;
  logic [REG_NUM_W-1:0]   r_wr_num;
  logic [REG_NUM_W-1:0]   r_rd1_num;
  logic [REG_NUM_W-1:0]   r_rd2_num;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rsp_data1;
  logic [DATA_W-1:0]      r_rsp_data2;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [NUM_REQ-1:0]     w_grant;
  logic                   w_idx;

  rr_arbiter2 u_rr_arbiter2 (
    .i_req        (req_valid),
    .i_last_grant (r_last_gnt),
    .o_grant      (w_grant)
  );

  assign w_idx = w_grant[1];

  // Ready is offered only in IDLE, and only to the current winner
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (r_state == ST_IDLE) begin
      req_ready = w_grant;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Transaction FSM; rf_* fields stay latched from the accept edge through RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_gnt  <= 1'b1;
      r_gnt       <= {NUM_REQ{1'b0}};
      r_we        <= 1'b0;
      r_wr_num    <= {REG_NUM_W{1'b0}};
      r_rd1_num   <= {REG_NUM_W{1'b0}};
      r_rd2_num   <= {REG_NUM_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_rsp_data1 <= {DATA_W{1'b0}};
      r_rsp_data2 <= {DATA_W{1'b0}};
      r_rsp_valid <= {NUM_REQ{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_gnt      <= w_grant;
            r_last_gnt <= w_idx;
            r_we       <= req_write[w_idx];
            r_wr_num   <= req_wr_num[int'(w_idx)*REG_NUM_W +: REG_NUM_W];
            r_rd1_num  <= req_rd1_num[int'(w_idx)*REG_NUM_W +: REG_NUM_W];
            r_rd2_num  <= req_rd2_num[int'(w_idx)*REG_NUM_W +: REG_NUM_W];
            r_wdata    <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_we        <= 1'b0;
          r_rsp_data1 <= rf_read_data_1;
          r_rsp_data2 <= rf_read_data_2;
          r_rsp_valid <= r_gnt;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (|(rsp_ready & r_gnt)) begin
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_we        <= 1'b0;
          r_rsp_valid <= {NUM_REQ{1'b0}};
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset masks the strobe at once so a write caught in ISSUE never lands
  assign rf_write_enable   = r_we & ~reset;
  assign rf_write_reg_num  = r_wr_num;
  assign rf_read_reg_1_num = r_rd1_num;
  assign rf_read_reg_2_num = r_rd2_num;
  assign rf_write_data     = r_wdata;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_data1         = r_rsp_data1;
  assign rsp_data2         = r_rsp_data2;
  assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a negedge-updating register file model.
module tb_regfile_port_arbiter;

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] d1;
    logic [15:0] d2;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [3:0]  req_wr_num, req_rd1_num, req_rd2_num;
  logic [31:0] req_wdata;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [15:0] rsp_data1, rsp_data2;
  logic        rf_write_enable;
  logic [1:0]  rf_write_reg_num, rf_read_reg_1_num, rf_read_reg_2_num;
  logic [15:0] rf_write_data, rf_read_data_1, rf_read_data_2;
  logic        busy;

  logic [15:0] rf_mem [4];
  logic [15:0] shadow [4];
  exp_t        sb [$];
  int          grant_log [$];
  int          n_tests, n_fail, we_cnt;
  logic [15:0] last_d1, last_d2;

  regfile_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wr_num(req_wr_num), .req_rd1_num(req_rd1_num), .req_rd2_num(req_rd2_num),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .rf_write_enable(rf_write_enable), .rf_write_reg_num(rf_write_reg_num),
    .rf_read_reg_1_num(rf_read_reg_1_num), .rf_read_reg_2_num(rf_read_reg_2_num),
    .rf_write_data(rf_write_data),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: read ports and write both update on the falling edge
  always @(negedge clk) begin
    rf_read_data_1 <= rf_mem[rf_read_reg_1_num];
    rf_read_data_2 <= rf_mem[rf_read_reg_2_num];
    if (rf_write_enable) rf_mem[rf_write_reg_num] <= rf_write_data;
    if (rf_write_enable) we_cnt = we_cnt + 1;
  end

  // Response monitor: pop and compare on each completed handshake
  always @(negedge clk) begin
    if (!reset && ((rsp_valid & rsp_ready) != 2'b00)) begin
      n_tests = n_tests + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL rsp_unexpected: got vld=%b d1=%h d2=%h, expected no response", rsp_valid, rsp_data1, rsp_data2);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rsp_valid, rsp_data1, rsp_data2} !== {e.vld, e.d1, e.d2}) begin
          n_fail = n_fail + 1;
          $display("FAIL rsp_data: got vld=%b d1=%h d2=%h, expected vld=%b d1=%h d2=%h",
                   rsp_valid, rsp_data1, rsp_data2, e.vld, e.d1, e.d2);
        end
        last_d1 = rsp_data1;
        last_d2 = rsp_data2;
      end
    end
  end

  task automatic send(input int id, input logic wr, input logic [1:0] wn,
                      input logic [1:0] r1, input logic [1:0] r2, input logic [15:0] wd);
    int k;
    exp_t e;
    @(posedge clk); #1;
    req_write[id]          = wr;
    req_wr_num[id*2 +: 2]  = wn;
    req_rd1_num[id*2 +: 2] = r1;
    req_rd2_num[id*2 +: 2] = r2;
    req_wdata[id*16 +: 16] = wd;
    req_valid[id]          = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k = k + 1;
    end while (!req_ready[id] && k < 40);
    if (!req_ready[id]) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL grant_timeout: requester %0d got no ready within %0d cycles, expected a grant", id, k);
    end else begin
      e.vld = (id == 0) ? 2'b01 : 2'b10;
      e.d1  = shadow[r1];
      e.d2  = shadow[r2];
      sb.push_back(e);
      if (wr) shadow[wn] = wd;
      grant_log.push_back(id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 60) begin
      @(negedge clk);
      k = k + 1;
    end
    n_tests = n_tests + 1;
    if (k >= 60) begin
      n_fail = n_fail + 1;
      $display("FAIL drain_timeout: pending=%0d busy=%b, expected 0 pending and idle", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests = n_tests + 1;
    if ({busy, req_ready, rsp_valid, rf_write_enable} !== 6'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_ctrl: got busy=%b ready=%b rsp_valid=%b we=%b, expected all 0",
               busy, req_ready, rsp_valid, rf_write_enable);
    end
    n_tests = n_tests + 1;
    if ({rf_write_reg_num, rf_read_reg_1_num, rf_read_reg_2_num, rf_write_data, rsp_data1, rsp_data2} !== 54'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_data: got nums=%h/%h/%h wdata=%h rsp=%h/%h, expected all 0",
               rf_write_reg_num, rf_read_reg_1_num, rf_read_reg_2_num, rf_write_data, rsp_data1, rsp_data2);
    end
  endtask

  task automatic test_contention();
    int exp_log [7] = '{0, 1, 0, 1, 0, 1, 0};
    for (int r = 0; r < 2; r++) begin
      fork
        send(0, 1'b0, 2'd0, 2'd0, 2'd3, 16'h0000);
        send(1, 1'b0, 2'd0, 2'd2, 2'd1, 16'h0000);
      join
      wait_drain();
    end
    send(0, 1'b0, 2'd0, 2'd1, 2'd2, 16'h0000);
    wait_drain();
    fork
      send(0, 1'b0, 2'd0, 2'd3, 2'd3, 16'h0000);
      send(1, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
    join
    wait_drain();
    n_tests = n_tests + 1;
    if (grant_log.size() != 7) begin
      n_fail = n_fail + 1;
      $display("FAIL grant_count: got %0d grants, expected 7", grant_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests = n_tests + 1;
        if (grant_log[i] !== exp_log[i]) begin
          n_fail = n_fail + 1;
          $display("FAIL grant_order[%0d]: got requester %0d, expected %0d", i, grant_log[i], exp_log[i]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int we0;
    we0 = we_cnt;
    send(0, 1'b1, 2'd2, 2'd0, 2'd0, 16'hA5A5);
    wait_drain();
    n_tests = n_tests + 1;
    if (we_cnt - we0 !== 1) begin
      n_fail = n_fail + 1;
      $display("FAIL write_pulse: got %0d enable cycles, expected 1", we_cnt - we0);
    end
    we0 = we_cnt;
    send(0, 1'b0, 2'd0, 2'd2, 2'd2, 16'h0000);
    wait_drain();
    n_tests = n_tests + 1;
    if ({last_d1, last_d2, we_cnt - we0} !== {16'hA5A5, 16'hA5A5, 32'd0}) begin
      n_fail = n_fail + 1;
      $display("FAIL read_back_r2: got d1=%h d2=%h we_cycles=%0d, expected a5a5 a5a5 0", last_d1, last_d2, we_cnt - we0);
    end
  endtask

  task automatic test_write_readback();
    send(1, 1'b1, 2'd1, 2'd1, 2'd2, 16'h1234);
    wait_drain();
    n_tests = n_tests + 1;
    if ({last_d1, last_d2} !== {16'h0000, 16'hA5A5}) begin
      n_fail = n_fail + 1;
      $display("FAIL pre_write_value: got d1=%h d2=%h, expected 0000 a5a5", last_d1, last_d2);
    end
    send(0, 1'b0, 2'd0, 2'd1, 2'd0, 16'h0000);
    wait_drain();
    n_tests = n_tests + 1;
    if ({last_d1, last_d2} !== {16'h1234, 16'h0000}) begin
      n_fail = n_fail + 1;
      $display("FAIL post_write_value: got d1=%h d2=%h, expected 1234 0000", last_d1, last_d2);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] h1, h2;
    rsp_ready = 2'b10;
    send(0, 1'b0, 2'd0, 2'd2, 2'd1, 16'h0000);
    @(negedge clk);
    n_tests = n_tests + 1;
    if ({rsp_valid, busy} !== 3'b001) begin
      n_fail = n_fail + 1;
      $display("FAIL latency_issue: got rsp_valid=%b busy=%b, expected 00 1", rsp_valid, busy);
    end
    @(negedge clk);
    n_tests = n_tests + 1;
    if ({rsp_valid, rsp_data1, rsp_data2} !== {2'b01, 16'hA5A5, 16'h1234}) begin
      n_fail = n_fail + 1;
      $display("FAIL latency_resp: got vld=%b d1=%h d2=%h, expected 01 a5a5 1234", rsp_valid, rsp_data1, rsp_data2);
    end
    h1 = 16'hA5A5;
    h2 = 16'h1234;
    @(posedge clk); #1;
    req_write   = 2'b11;
    req_wr_num  = 4'hF;
    req_rd1_num = 4'h5;
    req_rd2_num = 4'hA;
    req_wdata   = 32'hDEAD_BEEF;
    req_valid   = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests = n_tests + 1;
      if ({rsp_valid, rsp_data1, rsp_data2, req_ready, busy, rf_write_enable} !== {2'b01, h1, h2, 2'b00, 1'b1, 1'b0}) begin
        n_fail = n_fail + 1;
        $display("FAIL hold_cycle%0d: got vld=%b d1=%h d2=%h ready=%b busy=%b we=%b, expected 01 %h %h 00 1 0",
                 c, rsp_valid, rsp_data1, rsp_data2, req_ready, busy, rf_write_enable, h1, h2);
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_write = 2'b00;
    rsp_ready = 2'b11;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req_write[0]      = 1'b1;
    req_wr_num[1:0]   = 2'd3;
    req_rd1_num[1:0]  = 2'd3;
    req_rd2_num[1:0]  = 2'd3;
    req_wdata[15:0]   = 16'hFFFF;
    req_valid[0]      = 1'b1;
    @(negedge clk);
    n_tests = n_tests + 1;
    if (req_ready !== 2'b01) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_accept: got ready=%b, expected 01", req_ready);
    end
    @(posedge clk); #1;
    reset        = 1'b1;
    req_valid[0] = 1'b0;
    req_write[0] = 1'b0;
    @(negedge clk);
    n_tests = n_tests + 1;
    if (rf_write_enable !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_we_masked: got we=%b, expected 0", rf_write_enable);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests = n_tests + 1;
    if ({busy, rsp_valid} !== 3'b000) begin
      n_fail = n_fail + 1;
      $display("FAIL mid_discard: got busy=%b rsp_valid=%b, expected 0 00", busy, rsp_valid);
    end
    send(0, 1'b0, 2'd0, 2'd3, 2'd3, 16'h0000);
    wait_drain();
    n_tests = n_tests + 1;
    if ({last_d1, last_d2} !== {16'h0000, 16'h0000}) begin
      n_fail = n_fail + 1;
      $display("FAIL r3_not_written: got d1=%h d2=%h, expected 0000 0000", last_d1, last_d2);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; we_cnt = 0;
    last_d1 = 16'h0000; last_d2 = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      rf_mem[i] = 16'h0000;
      shadow[i] = 16'h0000;
    end
    reset = 1'b1;
    req_valid = 2'b00; req_write = 2'b00;
    req_wr_num = 4'h0; req_rd1_num = 4'h0; req_rd2_num = 4'h0;
    req_wdata = 32'h0; rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_contention();
    test_write_read();
    test_write_readback();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
